// File: rtl/ram_access_arbiter_if.sv
// Requester-side and RAM-side signals of ram_access_arbiter, bundled so that the
// arbiter takes one port; master is the environment view, slave the arbiter view.
interface ram_access_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 64
);
   logic [NUM_REQ-1:0]        wr_req;
   logic [NUM_REQ*ADDR_W-1:0] wr_addr;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        wr_gnt;
   logic [NUM_REQ-1:0]        rd_req;
   logic [NUM_REQ*ADDR_W-1:0] rd_addr;
   logic [NUM_REQ-1:0]        rd_gnt;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic                      ram_wr;
   logic [ADDR_W-1:0]         ram_wr_add;
   logic [DATA_W-1:0]         ram_in;
   logic                      ram_rd;
   logic [ADDR_W-1:0]         ram_rd_add;
   logic [DATA_W-1:0]         ram_out;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_out,
      input  wr_gnt, rd_gnt, rd_valid, rd_data,
      input  ram_wr, ram_wr_add, ram_in, ram_rd, ram_rd_add
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_out,
      output wr_gnt, rd_gnt, rd_valid, rd_data,
      output ram_wr, ram_wr_add, ram_in, ram_rd, ram_rd_add
   );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbitration of NUM_REQ requesters onto the write and read ports of a
// dual-port RAM, with registered RAM commands and read-data routing back to the issuer.
module ram_access_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned RD_LAT  = 1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   ram_access_arbiter_if.slave bus
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef logic [ID_W-1:0] id_t;

   id_t               r_wr_last;
   id_t               r_rd_last;
   logic              r_ram_wr;
   logic [ADDR_W-1:0] r_ram_wr_add;
   logic [DATA_W-1:0] r_ram_in;
   logic              r_ram_rd;
   logic [ADDR_W-1:0] r_ram_rd_add;
   logic [RD_LAT:0]   r_pipe_vld;
   id_t  [RD_LAT:0]   r_pipe_id;

   logic              w_wr_found;
   logic              w_rd_found;
   id_t               w_wr_cand;
   id_t               w_rd_cand;
   logic [ADDR_W-1:0] w_wr_cand_addr;
   logic [DATA_W-1:0] w_wr_cand_data;
   logic [ADDR_W-1:0] w_rd_cand_addr;
   logic              w_collide;
   logic              w_wr_take;
   logic              w_rd_take;

   // Returns {found, index} of the first request after 'last', wrapping modulo NUM_REQ.
   function automatic logic [ID_W:0] f_rr_pick(input logic [NUM_REQ-1:0] req, input id_t last);
      logic        found;
      id_t         idx;
      int unsigned pos;
      found = 1'b0;
      idx   = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         pos = (32'(last) + off) % NUM_REQ;
         if (!found && req[id_t'(pos)]) begin
            found = 1'b1;
            idx   = id_t'(pos);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      {w_wr_found, w_wr_cand} = f_rr_pick(bus.wr_req, r_wr_last);
      {w_rd_found, w_rd_cand} = f_rr_pick(bus.rd_req, r_rd_last);
      w_wr_cand_addr = bus.wr_addr[w_wr_cand*ADDR_W +: ADDR_W];
      w_wr_cand_data = bus.wr_data[w_wr_cand*DATA_W +: DATA_W];
      w_rd_cand_addr = bus.rd_addr[w_rd_cand*ADDR_W +: ADDR_W];
      // Same-address write wins; the read retries once the write sits in the RAM register.
      w_collide = w_wr_found & w_rd_found & (w_wr_cand_addr == w_rd_cand_addr);
      w_wr_take = w_wr_found & ~i_rst;
      w_rd_take = w_rd_found & ~w_collide & ~i_rst;

      bus.wr_gnt              = '0;
      bus.wr_gnt[w_wr_cand]   = w_wr_take;
      bus.rd_gnt              = '0;
      bus.rd_gnt[w_rd_cand]   = w_rd_take;
      bus.rd_valid            = '0;
      bus.rd_valid[r_pipe_id[RD_LAT]] = r_pipe_vld[RD_LAT] & ~i_rst;
   end

   assign bus.rd_data    = bus.ram_out;
   assign bus.ram_wr     = r_ram_wr;
   assign bus.ram_wr_add = r_ram_wr_add;
   assign bus.ram_in     = r_ram_in;
   assign bus.ram_rd     = r_ram_rd;
   assign bus.ram_rd_add = r_ram_rd_add;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_last    <= id_t'(NUM_REQ - 1);
         r_rd_last    <= id_t'(NUM_REQ - 1);
         r_ram_wr     <= 1'b0;
         r_ram_wr_add <= '0;
         r_ram_in     <= '0;
         r_ram_rd     <= 1'b0;
         r_ram_rd_add <= '0;
         r_pipe_vld   <= '0;
      end else begin
         r_ram_wr   <= w_wr_take;
         r_ram_rd   <= w_rd_take;
         r_pipe_vld <= {r_pipe_vld[RD_LAT-1:0], w_rd_take};
         if (w_wr_take) begin
            r_wr_last    <= w_wr_cand;
            r_ram_wr_add <= w_wr_cand_addr;
            r_ram_in     <= w_wr_cand_data;
         end
         if (w_rd_take) begin
            r_rd_last    <= w_rd_cand;
            r_ram_rd_add <= w_rd_cand_addr;
         end
      end
   end

   // Requester ids only matter alongside their valid bits, so they need no reset.
   always_ff @(posedge i_clk) begin
      r_pipe_id <= {r_pipe_id[RD_LAT-1:0], w_rd_cand};
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: vector table, directed corner sequences
// and randomized traffic checked against a behavioural RAM/arbiter model.
module tb_ram_access_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 64;
   localparam int RD_LAT  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ram_access_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_access_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   // RAM model: write on the edge, read data RD_LAT edges after ram_rd is sampled.
   logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] ram_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.ram_wr) ram_mem[bus.ram_wr_add] <= bus.ram_in;
      ram_pipe[0] <= ram_mem[bus.ram_rd_add];
      for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
   end
   assign bus.ram_out = ram_pipe[RD_LAT-1];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, required self-termination");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.wr_req = '0;
      bus.rd_req = '0;
   endtask

   task automatic set_wr(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.wr_addr[i*ADDR_W +: ADDR_W] = a;
      bus.wr_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_rd(input int i, input logic [ADDR_W-1:0] a);
      bus.rd_addr[i*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_reqs();
      next();
      next();
      rst = 1'b0;
   endtask

   // Called at the sampling point of the grant cycle; follows the read to its return.
   task automatic expect_return(input int id, input logic [DATA_W-1:0] data);
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         next();
         if (k == 1) clear_reqs();
         @(negedge clk);
         if (k == 1) chk("ram_rd_issued", bus.ram_rd, 1);
         if (k <= RD_LAT) chk("rd_valid_early", bus.rd_valid, 0);
         else begin
            chk("rd_valid_id", bus.rd_valid, 64'(1) << id);
            chk("rd_data", bus.rd_data, data);
         end
      end
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] req, input int last);
      for (int off = 1; off <= NUM_REQ; off++)
         if (req[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
      return -1;
   endfunction

   typedef struct {
      logic [NUM_REQ-1:0] wr_req;
      logic [NUM_REQ-1:0] rd_req;
      logic [NUM_REQ-1:0] exp_wr;
      logic [NUM_REQ-1:0] exp_rd;
   } vec_t;

   typedef struct {
      int                due;
      int                id;
      bit                known;
      logic [DATA_W-1:0] data;
   } pend_t;

   vec_t vecs [15];

   initial begin
      logic              prev_any;
      logic [ADDR_W-1:0] prev_addr;
      logic [DATA_W-1:0] d;

      for (int r = 0; r < 8; r++) begin
         vecs[r] = '{4'b1111, 4'b0000, 4'(1 << (r % 4)), 4'b0000};
      end
      vecs[8]  = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      vecs[9]  = '{4'b1001, 4'b0000, 4'b0001, 4'b0000};
      vecs[10] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      vecs[11] = '{4'b0110, 4'b0110, 4'b0010, 4'b0010};
      vecs[12] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
      vecs[13] = '{4'b0000, 4'b1001, 4'b0000, 4'b1000};
      vecs[14] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};

      bus.wr_req  = '0;
      bus.rd_req  = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset_ram_wr", bus.ram_wr, 0);
      chk("reset_ram_rd", bus.ram_rd, 0);
      chk("reset_ram_wr_add", bus.ram_wr_add, 0);
      chk("reset_ram_in", bus.ram_in, 0);
      chk("reset_ram_rd_add", bus.ram_rd_add, 0);
      chk("reset_rd_valid", bus.rd_valid, 0);

      // Vector table: round-robin order, wrap, continuous ram_wr
      prev_any  = 1'b0;
      prev_addr = '0;
      for (int r = 0; r < 15; r++) begin
         next();
         for (int i = 0; i < NUM_REQ; i++) begin
            set_wr(i, 12'h100 + 12'(r * 4 + i), {32'(r), 32'(i)});
            set_rd(i, 12'h200 + 12'(i));
         end
         bus.wr_req = vecs[r].wr_req;
         bus.rd_req = vecs[r].rd_req;
         @(negedge clk);
         chk($sformatf("tbl%0d_wr_gnt", r), bus.wr_gnt, vecs[r].exp_wr);
         chk($sformatf("tbl%0d_rd_gnt", r), bus.rd_gnt, vecs[r].exp_rd);
         chk($sformatf("tbl%0d_ram_wr", r), bus.ram_wr, prev_any);
         if (prev_any) chk($sformatf("tbl%0d_ram_wr_add", r), bus.ram_wr_add, prev_addr);
         prev_any = |vecs[r].exp_wr;
         for (int i = 0; i < NUM_REQ; i++)
            if (vecs[r].exp_wr[i]) prev_addr = 12'h100 + 12'(r * 4 + i);
      end

      // Write by requester 2, read back by requester 1
      do_reset();
      d = 64'hDEAD_BEEF_0000_0001;
      set_wr(2, 12'h00A, d);
      bus.wr_req = 4'b0100;
      @(negedge clk);
      chk("a_wr_gnt", bus.wr_gnt, 4'b0100);
      chk("a_ram_wr_before", bus.ram_wr, 0);
      next();
      clear_reqs();
      @(negedge clk);
      chk("a_ram_wr", bus.ram_wr, 1);
      chk("a_ram_wr_add", bus.ram_wr_add, 12'h00A);
      chk("a_ram_in", bus.ram_in, d);
      next();
      set_rd(1, 12'h00A);
      bus.rd_req = 4'b0010;
      @(negedge clk);
      chk("a_rd_gnt", bus.rd_gnt, 4'b0010);
      expect_return(1, d);

      // Same-cycle write and read to 0xFFF: write wins, read follows
      next();
      d = 64'h0123_4567_89AB_CDEF;
      set_wr(0, 12'hFFF, d);
      set_rd(3, 12'hFFF);
      bus.wr_req = 4'b0001;
      bus.rd_req = 4'b1000;
      @(negedge clk);
      chk("b_wr_gnt", bus.wr_gnt, 4'b0001);
      chk("b_rd_gnt_blocked", bus.rd_gnt, 4'b0000);
      next();
      bus.wr_req = '0;
      @(negedge clk);
      chk("b_rd_gnt", bus.rd_gnt, 4'b1000);
      expect_return(3, d);

      // Back-to-back reads from requesters 0 and 1
      next();
      set_wr(0, 12'h010, 64'hAAAA_0000_0000_0010);
      set_wr(1, 12'h020, 64'hBBBB_0000_0000_0020);
      bus.wr_req = 4'b0011;
      @(negedge clk);
      chk("c_wr_gnt1", bus.wr_gnt, 4'b0010);
      next();
      bus.wr_req = 4'b0001;
      @(negedge clk);
      chk("c_wr_gnt0", bus.wr_gnt, 4'b0001);
      next();
      bus.wr_req = '0;
      set_rd(0, 12'h010);
      bus.rd_req = 4'b0001;
      @(negedge clk);
      chk("c_rd_gnt0", bus.rd_gnt, 4'b0001);
      next();
      set_rd(1, 12'h020);
      bus.rd_req = 4'b0010;
      @(negedge clk);
      chk("c_rd_gnt1", bus.rd_gnt, 4'b0010);
      for (int c = 2; c <= RD_LAT + 2; c++) begin
         next();
         clear_reqs();
         @(negedge clk);
         if (c == RD_LAT + 1) begin
            chk("c_rd_valid0", bus.rd_valid, 4'b0001);
            chk("c_rd_data0", bus.rd_data, 64'hAAAA_0000_0000_0010);
         end else if (c == RD_LAT + 2) begin
            chk("c_rd_valid1", bus.rd_valid, 4'b0010);
            chk("c_rd_data1", bus.rd_data, 64'hBBBB_0000_0000_0020);
         end else chk("c_rd_valid_early", bus.rd_valid, 0);
      end

      // Reset while a read is in flight
      next();
      set_rd(0, 12'h00A);
      bus.rd_req = 4'b0001;
      @(negedge clk);
      chk("d_rd_gnt", bus.rd_gnt, 4'b0001);
      next();
      rst = 1'b1;
      bus.rd_req = '0;
      set_wr(3, 12'h033, 64'h3);
      set_wr(0, 12'h030, 64'h0);
      bus.wr_req = 4'b1000;
      @(negedge clk);
      chk("d_wr_gnt_in_rst", bus.wr_gnt, 0);
      chk("d_rd_valid_in_rst", bus.rd_valid, 0);
      next();
      rst = 1'b0;
      bus.wr_req = 4'b1001;
      @(negedge clk);
      chk("d_wr_gnt_after_rst", bus.wr_gnt, 4'b0001);
      chk("d_rd_valid_after_rst", bus.rd_valid, 0);
      for (int k = 0; k < RD_LAT + 2; k++) begin
         next();
         clear_reqs();
         @(negedge clk);
         chk("d_no_rd_valid", bus.rd_valid, 0);
      end

      // Randomized traffic against the behavioural model
      begin
         logic [ADDR_W-1:0]  w_a [NUM_REQ];
         logic [DATA_W-1:0]  w_d [NUM_REQ];
         logic [ADDR_W-1:0]  r_a [NUM_REQ];
         logic [NUM_REQ-1:0] wv;
         logic [NUM_REQ-1:0] rv;
         logic [DATA_W-1:0]  m_mem [16];
         bit                 m_known [16];
         pend_t              pq [$];
         pend_t              p;
         int                 m_wl;
         int                 m_rl;
         int                 wi;
         int                 ri;
         bit                 prev_wr;
         logic [NUM_REQ-1:0] exp_rv;

         do_reset();
         m_wl    = NUM_REQ - 1;
         m_rl    = NUM_REQ - 1;
         prev_wr = 1'b0;
         wv      = '0;
         rv      = '0;
         for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            next();
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!wv[i] && $urandom_range(0, 2) == 0) begin
                  wv[i]  = 1'b1;
                  w_a[i] = 12'h400 + 12'($urandom_range(0, 15));
                  w_d[i] = {$urandom, $urandom};
               end
               if (!rv[i] && $urandom_range(0, 2) == 0) begin
                  rv[i]  = 1'b1;
                  r_a[i] = 12'h400 + 12'($urandom_range(0, 15));
               end
               if (wv[i]) set_wr(i, w_a[i], w_d[i]);
               if (rv[i]) set_rd(i, r_a[i]);
            end
            bus.wr_req = wv;
            bus.rd_req = rv;
            @(negedge clk);
            wi = pick(wv, m_wl);
            ri = pick(rv, m_rl);
            if (wi >= 0 && ri >= 0 && w_a[wi] == r_a[ri]) ri = -1;
            chk("rnd_wr_gnt", bus.wr_gnt, (wi >= 0) ? (64'(1) << wi) : 64'(0));
            chk("rnd_rd_gnt", bus.rd_gnt, (ri >= 0) ? (64'(1) << ri) : 64'(0));
            chk("rnd_ram_wr", bus.ram_wr, prev_wr);
            exp_rv = '0;
            p      = '{0, 0, 1'b0, '0};
            if (pq.size() > 0 && pq[0].due == c) begin
               p      = pq.pop_front();
               exp_rv = 4'(1 << p.id);
            end
            chk("rnd_rd_valid", bus.rd_valid, exp_rv);
            if (exp_rv != 0 && p.known) chk("rnd_rd_data", bus.rd_data, p.data);
            if (ri >= 0) begin
               pq.push_back('{c + 1 + RD_LAT, ri, m_known[r_a[ri][3:0]], m_mem[r_a[ri][3:0]]});
               rv[ri] = 1'b0;
               m_rl   = ri;
            end
            if (wi >= 0) begin
               m_mem[w_a[wi][3:0]]   = w_d[wi];
               m_known[w_a[wi][3:0]] = 1'b1;
               wv[wi] = 1'b0;
               m_wl   = wi;
            end
            prev_wr = (wi >= 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
